// File: rtl/hilo_unit.sv
// HI/LO architectural register pair: captures multiplier/divider results,
// sequences mult/div issue, services MFHI/MFLO/MTHI/MTLO and watchdogs hung units.
module hilo_unit #(
  parameter int unsigned MULT_TIMEOUT = 40,
  parameter int unsigned DIV_TIMEOUT  = 40,
  parameter int unsigned CNT_W        = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [1:0]  mult_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_done,
  input  logic        div_zero,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        issue_err,
  output logic        dz_flag,
  output logic        timeout_err
);

  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MULT_BUSY = 2'd1,
    DIV_BUSY  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]   hi_q, hi_d;
  logic [DataW-1:0]   lo_q, lo_d;
  logic               issue_err_q, issue_err_d;
  logic               dz_flag_q, dz_flag_d;
  logic               timeout_err_q, timeout_err_d;
  logic               any_req;

  assign any_req = start_mult | start_div | mthi_we | mtlo_we;

  // State register and architectural flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      issue_err_q   <= 1'b0;
      dz_flag_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      issue_err_q   <= issue_err_d;
      dz_flag_q     <= dz_flag_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state: issue, capture, watchdog abort and illegal-request detection
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    issue_err_d   = 1'b0;
    dz_flag_d     = dz_flag_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d       = MULT_BUSY;
          cnt_d         = '0;
          dz_flag_d     = 1'b0;
          timeout_err_d = 1'b0;
          issue_err_d   = start_div;
        end else if (start_div) begin
          state_d       = DIV_BUSY;
          cnt_d         = '0;
          dz_flag_d     = 1'b0;
          timeout_err_d = 1'b0;
        end
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
      end

      MULT_BUSY: begin
        cnt_d       = cnt_q + CNT_W'(1);
        issue_err_d = any_req;
        // A done coincident with the final watchdog cycle still captures
        if (mult_done == 2'd1) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(MULT_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end

      DIV_BUSY: begin
        cnt_d       = cnt_q + CNT_W'(1);
        issue_err_d = any_req;
        if (div_done) begin
          if (div_zero) begin
            dz_flag_d = 1'b1;
          end else begin
            hi_d = div_hi;
            lo_d = div_lo;
          end
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign stall       = rd_req & busy;
  assign rd_data     = rd_sel ? hi_q : lo_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign issue_err   = issue_err_q;
  assign dz_flag     = dz_flag_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Holds the architectural HI/LO register pair for the MIPS core.
- Sits directly downstream of the multiplier and divider and captures their 64-bit results on completion.
- Sequences mult/div issue from control; services MFHI/MFLO reads, stalling them while an operation is in flight.
- Services MTHI/MTLO writes and flags illegal overlaps and hung units.

Parameters:
- MULT_TIMEOUT, 40, max cycles in MULT_BUSY without a done before abort.
- DIV_TIMEOUT, 40, max cycles in DIV_BUSY without a done before abort.
- CNT_W, 6, watchdog counter width; must hold max(MULT_TIMEOUT, DIV_TIMEOUT).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- start_mult  in  1  one-cycle issue pulse for MULT.
- start_div  in  1  one-cycle issue pulse for DIV.
- mult_hi  in  32  multiplier product [63:32].
- mult_lo  in  32  multiplier product [31:0].
- mult_done  in  2  multiplier status; 2'd1 for exactly one cycle marks mult_hi/mult_lo valid.
- div_hi  in  32  remainder.
- div_lo  in  32  quotient.
- div_done  in  1  one-cycle pulse, div_hi/div_lo/div_zero valid.
- div_zero  in  1  divisor was zero; qualified by div_done.
- mthi_we  in  1  MTHI write enable.
- mtlo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO data.
- rd_req  in  1  MFHI/MFLO read request.
- rd_sel  in  1  0 = LO, 1 = HI.
- rd_data  out  32  combinational: rd_sel ? hi_out : lo_out.
- stall  out  1  combinational: rd_req && busy.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.
- busy  out  1  state != IDLE.
- issue_err  out  1  registered one-cycle pulse on an illegal issue or write.
- dz_flag  out  1  sticky: last DIV had divisor zero.
- timeout_err  out  1  sticky: last op aborted by the watchdog.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; hi_out=lo_out=0; cnt=0.
  - issue_err=dz_flag=timeout_err=0.
  - Mid-operation reset abandons the op; any later done pulse arriving in IDLE is ignored.
- States: IDLE, MULT_BUSY, DIV_BUSY.
- IDLE:
  - start_mult -> MULT_BUSY, cnt<=0.
  - start_div -> DIV_BUSY, cnt<=0.
  - Both asserted together: MULT wins, issue_err pulses.
  - Any accepted start clears dz_flag and timeout_err.
  - mthi_we: hi_out<=wdata next edge. mtlo_we: lo_out<=wdata. Both may write in the same cycle.
  - A write coincident with a start is performed; the start is still accepted.
  - mult_done/div_done in IDLE are ignored.
- MULT_BUSY:
  - cnt increments every cycle.
  - mult_done==2'd1: hi_out<=mult_hi, lo_out<=mult_lo, -> IDLE.
  - mult_done values 2'd0, 2'd2, 2'd3 are ignored; div_done is ignored.
  - cnt==MULT_TIMEOUT-1 with no done: -> IDLE, timeout_err<=1, HI/LO unchanged.
  - A done in the same cycle as the timeout wins: capture, no error.
- DIV_BUSY:
  - cnt increments every cycle.
  - div_done && !div_zero: hi_out<=div_hi, lo_out<=div_lo, -> IDLE.
  - div_done && div_zero: HI/LO unchanged, dz_flag<=1, -> IDLE.
  - mult_done is ignored.
  - Timeout is handled as in MULT_BUSY, using DIV_TIMEOUT.
- In either BUSY state:
  - start_mult, start_div, mthi_we or mtlo_we: request ignored, issue_err pulses one cycle.
- Latency:
  - Captured result is visible on hi_out/lo_out and rd_data one cycle after the done cycle.
  - busy deasserts on that same cycle.
  - stall is high during the done cycle itself, so a stalled read retried on the next cycle returns the new value.
- Reads are never registered: rd_data reflects current HI/LO even when stall=1; the consumer must discard it.
- No read-after-write bypass: MFHI in the same cycle as MTHI returns the old HI.

Test Plan:
- Reset, then start_mult; mult_done=1 three cycles later with mult_hi=0, mult_lo=32'h2A -> hi_out=0, lo_out=32'h2A one cycle after done; busy high only between the start cycle and the done cycle.
- During MULT_BUSY, rd_req=1, rd_sel=1 -> stall=1 on every cycle through the done cycle; on the next cycle stall=0 and rd_data=mult_hi.
- start_div; div_done with div_lo=14, div_hi=2, div_zero=0 -> lo_out=14, hi_out=2; dz_flag=0.
- Preload HI/LO=32'h1111/32'h2222 via MTHI/MTLO; DIV with div_done and div_zero=1 -> HI/LO unchanged, dz_flag=1; next start_mult clears dz_flag.
- start_mult with no mult_done for MULT_TIMEOUT cycles -> busy falls, timeout_err=1, HI/LO unchanged; a late mult_done=1 arriving in IDLE leaves HI/LO unchanged.
- In MULT_BUSY: assert mthi_we (wdata=32'hDEAD) and start_div -> issue_err pulses, hi_out unchanged, state stays MULT_BUSY. Separately, drop reset mid-op -> all outputs 0 immediately, without waiting for a clock edge.
